ddr3_buf_regs: RTL and testbench
================================

# ddr3_buf_regs

Parametrised successor to the DDR3 CSR bank: a single-clock control/status block holding NUM_BUF frame-buffer offsets with arm/clear ownership flags, a DATA_W-wide test read/write port with busy tracking and timeout, sticky overflow/timeout status, and an optional interrupt. It sits between the CSR bus and the DDR3 read/write engines, in the DDR3 clock domain, so no handshake synchronisers are needed.

## Interface
- NUM_BUF, 2, buffer channels (1..8)
- ADDR_W, 26, offset width per buffer (1..32)
- DATA_W, 128, test data width (32..256, multiple of 32)
- TIMEOUT, 65535, cycles a test op may stay busy; 0 disables the timeout
- clk  in  1  single clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high reset
- csr_read  in  1  read strobe
- csr_write  in  1  write strobe
- csr_addr  in  8  word address
- csr_wr_data  in  32  write data
- csr_rd_data  out  32  registered read data
- buf_offset  out  NUM_BUF*ADDR_W  offsets; buffer i at [i*ADDR_W +: ADDR_W]
- buf_full  out  NUM_BUF  buffer i armed (owned by consumer)
- buf_clear  in  NUM_BUF  consumer releases buffer i (1-cycle pulse)
- test_addr  out  32  test address
- test_wr_data  out  DATA_W  test write data
- test_wr_req  out  1  1-cycle write request
- test_rd_req  out  1  1-cycle read request
- wr_finish  in  1  write engine done
- rd_finish  in  1  read engine done
- test_rd_data  in  DATA_W  read result, valid with rd_finish
- irq  out  1  level interrupt

## Operation
- Register map (word addresses):
  - 0x00 ID RO: 32'hB00B0000 | NUM_BUF<<8 | DATA_W/32.
  - 0x01 CTRL: write bit0 = start write, bit1 = start read; read {29'd0, timeout, rd_busy, wr_busy}.
  - 0x02 STATUS: [NUM_BUF-1:0] buf_full RO; [8+i] overflow i W1C; [16] timeout W1C.
  - 0x03 ARM: write 1 to bit i sets buf_full[i]; read returns buf_full.
  - 0x04 IRQ_EN: [NUM_BUF-1:0] buffer-release enables, [16] test-done enable.
  - 0x05 IRQ_STAT W1C: bit i set when buffer i released; bit16 set on test completion or timeout.
  - 0x06 TEST_ADDR RW.
  - 0x08+k TEST_WR_DATA word k RW, k < DATA_W/32.
  - 0x10+k TEST_RD_DATA word k RO, captured on rd_finish.
  - 0x20+i buffer i offset RW, ADDR_W bits, upper bits read 0.
  - Unmapped: reads 0, writes ignored. Reads have no side effects.
- Buffer flag: arm sets, buf_clear clears. Arm and clear same cycle: arm wins, no release event. Arm while full: stays full, overflow i set. buf_clear while empty: ignored.
- Test port: one op at a time. Start ignored while wr_busy or rd_busy. Bits 0 and 1 both set: write starts, read ignored. Start pulses the req and sets its busy flag. Matching finish clears busy and sets IRQ_STAT[16]; non-matching finish ignored. rd_finish also captures test_rd_data.
- Timeout: counter clears on start and increments while busy; after TIMEOUT busy cycles without finish, busy clears and STATUS[16] and IRQ_STAT[16] set. Finish on the timeout cycle wins; no timeout flag.
- W1C write and a set event on the same bit in the same cycle: set wins.

## Timing
- Reset: every register 0; csr_rd_data=0, buf_offset=0, buf_full=0, test_addr=0, test_wr_data=0, reqs=0, irq=0, busy/timeout counter=0.
- csr_read: csr_rd_data valid next cycle, held until the next read.
- csr_write: effect visible on outputs next cycle; test req pulses exactly one cycle, in the cycle after the write.
- buf_clear or finish: flag or busy change at the next edge; irq follows the same edge.
- Reset mid-operation: busy, counter, and flags abort immediately; no req is emitted.

## Configuration
- DDR3_BUF_REGS_IRQ_EN defined: IRQ_EN and IRQ_STAT are implemented; irq = |(IRQ_STAT & IRQ_EN).
- DDR3_BUF_REGS_IRQ_EN undefined: irq is tied 0; 0x04 and 0x05 read 0 and ignore writes; the rest is unchanged.

## Test plan
- Write 0x1234 to 0x21, then read 0x21 -> buf_offset[ADDR_W +: ADDR_W]=0x1234 and the read returns 0x00001234; ID read returns 0xB00B0204 with defaults.
- Write ARM=0x1, then write ARM=0x1 again -> buf_full=01 and STATUS=0x101; write STATUS 0x100 -> STATUS=0x001.
- IRQ_EN=0x1, buffer 0 armed, buf_clear[0] pulse -> buf_full[0]=0, IRQ_STAT[0]=1, irq=1; write 0x1 to 0x05 -> irq=0.
- Buffer 0 armed; ARM=0x1 write coincides with buf_clear[0] -> buf_full[0] stays 1, IRQ_STAT[0]=0.
- CTRL=0x2, test_rd_data=0xA..., rd_finish after 5 cycles -> one-cycle test_rd_req, then 0x10 reads the captured word; CTRL=0x3 starts the write only.
- TIMEOUT=8, CTRL=0x1 with no finish -> wr_busy clears after 8 busy cycles; CTRL reads 0x4; a second start during busy gives no req.

Source files
------------

// File: rtl/ddr3_buf_regs_if.sv
// CSR bus between the register master and the ddr3_buf_regs bank.
// Word addressed; read data is registered inside the bank.
interface ddr3_buf_regs_if;
    logic        csr_read;
    logic        csr_write;
    logic [7:0]  csr_addr;
    logic [31:0] csr_wr_data;
    logic [31:0] csr_rd_data;

    modport master (
        output csr_read,
        output csr_write,
        output csr_addr,
        output csr_wr_data,
        input  csr_rd_data
    );

    modport slave (
        input  csr_read,
        input  csr_write,
        input  csr_addr,
        input  csr_wr_data,
        output csr_rd_data
    );
endinterface

// File: rtl/ddr3_buf_regs.sv
// DDR3 frame-buffer CSR bank: buffer offsets, arm/clear ownership flags, test port with timeout.
// Define DDR3_BUF_REGS_IRQ_EN to build the IRQ_EN/IRQ_STAT registers and the irq output.
module ddr3_buf_regs #(
    parameter int NUM_BUF = 2,
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    ddr3_buf_regs_if.slave            csr,
    output logic [NUM_BUF*ADDR_W-1:0] buf_offset,
    output logic [NUM_BUF-1:0]        buf_full,
    input  logic [NUM_BUF-1:0]        buf_clear,
    output logic [31:0]               test_addr,
    output logic [DATA_W-1:0]         test_wr_data,
    output logic                      test_wr_req,
    output logic                      test_rd_req,
    input  logic                      wr_finish,
    input  logic                      rd_finish,
    input  logic [DATA_W-1:0]         test_rd_data,
    output logic                      irq
);
    localparam int               CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int               TMO_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit               TMO_ON     = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TMO_LAST_C = CNT_W'(TMO_LAST);
    localparam logic [3:0]       NWORD      = 4'(DATA_W / 32);
    localparam logic [3:0]       NBUF       = 4'(NUM_BUF);
    localparam logic [31:0]      ID_VAL     = 32'hB00B_0000 | (32'(NUM_BUF) << 8) | 32'(DATA_W / 32);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } test_state_t;

    test_state_t               state_r, state_nxt_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [NUM_BUF*ADDR_W-1:0] buf_offset_r;
    logic [NUM_BUF-1:0]        buf_full_r, overflow_r;
    logic                      timeout_r;
    logic [31:0]               test_addr_r;
    logic [DATA_W-1:0]         test_wr_data_r, test_rd_data_r;
    logic                      test_wr_req_r, test_rd_req_r;
    logic [31:0]               rd_data_r, rd_mux_s;
    logic [31:0]               irq_en_rd_s, irq_stat_rd_s;

    logic [2:0]                sub_s;
    logic                      hit_wdata_s, hit_rdata_s, hit_off_s;
    logic                      ctrl_wr_s, status_wr_s;
    logic [NUM_BUF-1:0]        arm_s;
    logic                      start_wr_s, start_rd_s, wr_done_s, rd_done_s, tmo_hit_s, tmo_s;

    // Address decode and write strobes
    always_comb begin
        sub_s       = csr.csr_addr[2:0];
        hit_wdata_s = (csr.csr_addr[7:3] == 5'h01) && ({1'b0, sub_s} < NWORD);
        hit_rdata_s = (csr.csr_addr[7:3] == 5'h02) && ({1'b0, sub_s} < NWORD);
        hit_off_s   = (csr.csr_addr[7:3] == 5'h04) && ({1'b0, sub_s} < NBUF);
        ctrl_wr_s   = csr.csr_write && (csr.csr_addr == 8'h01);
        status_wr_s = csr.csr_write && (csr.csr_addr == 8'h02);
        if (csr.csr_write && (csr.csr_addr == 8'h03)) begin
            arm_s = csr.csr_wr_data[NUM_BUF-1:0];
        end else begin
            arm_s = {NUM_BUF{1'b0}};
        end
    end

    // Test-port FSM next state; only one operation may be outstanding
    always_comb begin
        wr_done_s   = (state_r == ST_WR) && wr_finish;
        rd_done_s   = (state_r == ST_RD) && rd_finish;
        tmo_hit_s   = TMO_ON && (cnt_r == TMO_LAST_C);
        state_nxt_s = state_r;
        start_wr_s  = 1'b0;
        start_rd_s  = 1'b0;
        tmo_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_wr_s && csr.csr_wr_data[0]) begin
                    start_wr_s  = 1'b1;
                    state_nxt_s = ST_WR;
                end else if (ctrl_wr_s && csr.csr_wr_data[1]) begin
                    start_rd_s  = 1'b1;
                    state_nxt_s = ST_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR: begin
                if (wr_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (tmo_hit_s) begin
                    tmo_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WR;
                end
            end
            ST_RD: begin
                if (rd_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (tmo_hit_s) begin
                    tmo_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Test-port state, busy counter, request pulses and read capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            test_wr_req_r  <= 1'b0;
            test_rd_req_r  <= 1'b0;
            test_rd_data_r <= {DATA_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            test_wr_req_r <= start_wr_s;
            test_rd_req_r <= start_rd_s;
            if (start_wr_s || start_rd_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (state_r != ST_IDLE) begin
                cnt_r <= cnt_r + 1'b1;
            end
            if (rd_done_s) begin
                test_rd_data_r <= test_rd_data;
            end
        end
    end

    // CSR storage, buffer ownership and sticky status; a set event beats a same-cycle W1C
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_offset_r   <= {(NUM_BUF*ADDR_W){1'b0}};
            buf_full_r     <= {NUM_BUF{1'b0}};
            overflow_r     <= {NUM_BUF{1'b0}};
            timeout_r      <= 1'b0;
            test_addr_r    <= 32'd0;
            test_wr_data_r <= {DATA_W{1'b0}};
        end else begin
            if (csr.csr_write && (csr.csr_addr == 8'h06)) begin
                test_addr_r <= csr.csr_wr_data;
            end
            if (csr.csr_write && hit_wdata_s) begin
                test_wr_data_r[sub_s*32 +: 32] <= csr.csr_wr_data;
            end
            if (csr.csr_write && hit_off_s) begin
                buf_offset_r[sub_s*ADDR_W +: ADDR_W] <= csr.csr_wr_data[ADDR_W-1:0];
            end
            buf_full_r <= arm_s | (buf_full_r & ~buf_clear);
            overflow_r <= (overflow_r & ~(status_wr_s ? csr.csr_wr_data[8 +: NUM_BUF] : {NUM_BUF{1'b0}}))
                          | (arm_s & buf_full_r);
            timeout_r  <= (timeout_r & ~(status_wr_s & csr.csr_wr_data[16])) | tmo_s;
        end
    end

`ifdef DDR3_BUF_REGS_IRQ_EN
    logic [NUM_BUF-1:0] irq_en_buf_r, irq_stat_buf_r, release_s;
    logic               irq_en_test_r, irq_stat_test_r;
    logic               irq_en_wr_s, irq_stat_wr_s;

    // A release is a clear of an armed buffer that is not re-armed in the same cycle
    always_comb begin
        irq_en_wr_s   = csr.csr_write && (csr.csr_addr == 8'h04);
        irq_stat_wr_s = csr.csr_write && (csr.csr_addr == 8'h05);
        release_s     = buf_clear & buf_full_r & ~arm_s;
        irq_en_rd_s   = 32'd0;
        irq_stat_rd_s = 32'd0;
        irq_en_rd_s[NUM_BUF-1:0]   = irq_en_buf_r;
        irq_en_rd_s[16]            = irq_en_test_r;
        irq_stat_rd_s[NUM_BUF-1:0] = irq_stat_buf_r;
        irq_stat_rd_s[16]          = irq_stat_test_r;
    end

    // Interrupt enable and W1C status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_buf_r    <= {NUM_BUF{1'b0}};
            irq_en_test_r   <= 1'b0;
            irq_stat_buf_r  <= {NUM_BUF{1'b0}};
            irq_stat_test_r <= 1'b0;
        end else begin
            if (irq_en_wr_s) begin
                irq_en_buf_r  <= csr.csr_wr_data[NUM_BUF-1:0];
                irq_en_test_r <= csr.csr_wr_data[16];
            end
            irq_stat_buf_r  <= (irq_stat_buf_r & ~(irq_stat_wr_s ? csr.csr_wr_data[NUM_BUF-1:0]
                                                                 : {NUM_BUF{1'b0}})) | release_s;
            irq_stat_test_r <= (irq_stat_test_r & ~(irq_stat_wr_s & csr.csr_wr_data[16]))
                               | wr_done_s | rd_done_s | tmo_s;
        end
    end

    assign irq = |(irq_stat_buf_r & irq_en_buf_r) | (irq_stat_test_r & irq_en_test_r);
`else
    assign irq_en_rd_s   = 32'd0;
    assign irq_stat_rd_s = 32'd0;
    assign irq           = 1'b0;
`endif

    // Read mux; reads never change state
    always_comb begin
        rd_mux_s = 32'd0;
        case (csr.csr_addr)
            8'h00: rd_mux_s = ID_VAL;
            8'h01: rd_mux_s = {29'd0, timeout_r, (state_r == ST_RD), (state_r == ST_WR)};
            8'h02: begin
                rd_mux_s[NUM_BUF-1:0]  = buf_full_r;
                rd_mux_s[8 +: NUM_BUF] = overflow_r;
                rd_mux_s[16]           = timeout_r;
            end
            8'h03: rd_mux_s[NUM_BUF-1:0] = buf_full_r;
            8'h04: rd_mux_s = irq_en_rd_s;
            8'h05: rd_mux_s = irq_stat_rd_s;
            8'h06: rd_mux_s = test_addr_r;
            default: begin
                if (hit_wdata_s) begin
                    rd_mux_s = test_wr_data_r[sub_s*32 +: 32];
                end else if (hit_rdata_s) begin
                    rd_mux_s = test_rd_data_r[sub_s*32 +: 32];
                end else if (hit_off_s) begin
                    rd_mux_s[ADDR_W-1:0] = buf_offset_r[sub_s*ADDR_W +: ADDR_W];
                end else begin
                    rd_mux_s = 32'd0;
                end
            end
        endcase
    end

    // Read data register, held between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= 32'd0;
        end else if (csr.csr_read) begin
            rd_data_r <= rd_mux_s;
        end
    end

    assign csr.csr_rd_data = rd_data_r;
    assign buf_offset      = buf_offset_r;
    assign buf_full        = buf_full_r;
    assign test_addr       = test_addr_r;
    assign test_wr_data    = test_wr_data_r;
    assign test_wr_req     = test_wr_req_r;
    assign test_rd_req     = test_rd_req_r;
endmodule

// File: tb/tb_ddr3_buf_regs.sv
// Directed self-checking bench for ddr3_buf_regs (TIMEOUT shortened to 8).
// IRQ expectations follow DDR3_BUF_REGS_IRQ_EN.
module tb_ddr3_buf_regs;
    localparam int NUM_BUF = 2;
    localparam int ADDR_W  = 26;
    localparam int DATA_W  = 128;
    localparam int TIMEOUT = 8;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_BUF*ADDR_W-1:0] buf_offset;
    logic [NUM_BUF-1:0]        buf_full;
    logic [NUM_BUF-1:0]        buf_clear;
    logic [31:0]               test_addr;
    logic [DATA_W-1:0]         test_wr_data;
    logic                      test_wr_req;
    logic                      test_rd_req;
    logic                      wr_finish;
    logic                      rd_finish;
    logic [DATA_W-1:0]         test_rd_data;
    logic                      irq;
    logic [31:0]               rd;
    int                        checks = 0;
    int                        errors = 0;

    ddr3_buf_regs_if bus ();

    ddr3_buf_regs #(
        .NUM_BUF(NUM_BUF), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .csr(bus),
        .buf_offset(buf_offset), .buf_full(buf_full), .buf_clear(buf_clear),
        .test_addr(test_addr), .test_wr_data(test_wr_data),
        .test_wr_req(test_wr_req), .test_rd_req(test_rd_req),
        .wr_finish(wr_finish), .rd_finish(rd_finish),
        .test_rd_data(test_rd_data), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
        bus.csr_write = 1'b1; bus.csr_addr = a; bus.csr_wr_data = d;
        @(negedge clk);
        bus.csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [7:0] a, output logic [31:0] d);
        bus.csr_read = 1'b1; bus.csr_addr = a;
        @(negedge clk);
        bus.csr_read = 1'b0;
        d = bus.csr_rd_data;
    endtask

    task automatic pulse_clear(input logic [NUM_BUF-1:0] m);
        buf_clear = m;
        @(negedge clk);
        buf_clear = '0;
    endtask

    initial begin
        reset = 1'b1;
        bus.csr_read = 1'b0; bus.csr_write = 1'b0; bus.csr_addr = 8'h00; bus.csr_wr_data = 32'd0;
        buf_clear = '0; wr_finish = 1'b0; rd_finish = 1'b0; test_rd_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_rd_data", bus.csr_rd_data, 32'd0);
        check_eq("rst_offset", buf_offset, 52'd0);
        check_eq("rst_full", buf_full, 2'b00);
        check_eq("rst_test_addr", test_addr, 32'd0);
        check_eq("rst_reqs", {test_wr_req, test_rd_req, irq}, 3'b000);
        reset = 1'b0;
        @(negedge clk);

        csr_rd(8'h00, rd);               check_eq("id", rd, 32'hB00B0204);
        repeat (2) @(negedge clk);
        check_eq("rd_hold", bus.csr_rd_data, 32'hB00B0204);
        csr_wr(8'h21, 32'h0000_1234);
        check_eq("offset1_out", buf_offset[ADDR_W +: ADDR_W], 26'h1234);
        check_eq("offset0_out", buf_offset[0 +: ADDR_W], 26'h0);
        csr_rd(8'h21, rd);               check_eq("offset1_rd", rd, 32'h0000_1234);
        csr_wr(8'h20, 32'hFFFF_FFFF);
        csr_rd(8'h20, rd);               check_eq("offset0_upper0", rd, 32'h03FF_FFFF);
        csr_wr(8'h06, 32'hDEAD_BEEF);
        check_eq("test_addr_out", test_addr, 32'hDEAD_BEEF);
        csr_wr(8'h0A, 32'h55AA_55AA);
        check_eq("wdata2_out", test_wr_data[64 +: 32], 32'h55AA_55AA);
        csr_rd(8'h0A, rd);               check_eq("wdata2_rd", rd, 32'h55AA_55AA);
        csr_wr(8'h07, 32'h1234_5678);
        csr_rd(8'h07, rd);               check_eq("unmapped", rd, 32'd0);
        csr_rd(8'h0C, rd);               check_eq("wdata_oob", rd, 32'd0);

        csr_wr(8'h03, 32'h1);
        csr_wr(8'h03, 32'h1);
        check_eq("arm_full", buf_full, 2'b01);
        csr_rd(8'h02, rd);               check_eq("status_ovf", rd, 32'h101);
        csr_wr(8'h02, 32'h100);
        csr_rd(8'h02, rd);               check_eq("status_w1c", rd, 32'h001);
        csr_rd(8'h03, rd);               check_eq("arm_rd", rd, 32'h1);

        csr_wr(8'h04, 32'h1);
        pulse_clear(2'b01);
        check_eq("clear_full", buf_full, 2'b00);
`ifdef DDR3_BUF_REGS_IRQ_EN
        check_eq("irq_release", irq, 1'b1);
        csr_rd(8'h05, rd);               check_eq("irqstat_rel", rd, 32'h1);
        csr_wr(8'h05, 32'h1);
        check_eq("irq_w1c", irq, 1'b0);
`else
        check_eq("irq_tied", irq, 1'b0);
        csr_rd(8'h04, rd);               check_eq("irqen_absent", rd, 32'd0);
`endif
        pulse_clear(2'b01);
        check_eq("clear_empty", buf_full, 2'b00);

        csr_wr(8'h03, 32'h1);
        bus.csr_write = 1'b1; bus.csr_addr = 8'h03; bus.csr_wr_data = 32'h1; buf_clear = 2'b01;
        @(negedge clk);
        bus.csr_write = 1'b0; buf_clear = '0;
        check_eq("arm_wins", buf_full, 2'b01);
`ifdef DDR3_BUF_REGS_IRQ_EN
        csr_rd(8'h05, rd);               check_eq("arm_wins_norel", rd, 32'h0);
`endif
        pulse_clear(2'b01);
        csr_wr(8'h02, 32'h0001_0300);
        csr_wr(8'h05, 32'h0001_00FF);
        csr_rd(8'h02, rd);               check_eq("status_clean", rd, 32'h0);

        test_rd_data = 128'hA5A5A5A5_33334444_11112222_A0A1A2A3;
        csr_wr(8'h01, 32'h2);
        check_eq("rd_req", {test_wr_req, test_rd_req}, 2'b01);
        wr_finish = 1'b1;
        @(negedge clk);
        wr_finish = 1'b0;
        check_eq("rd_req_1cyc", test_rd_req, 1'b0);
        csr_rd(8'h01, rd);               check_eq("rd_busy", rd, 32'h2);
        rd_finish = 1'b1;
        @(negedge clk);
        rd_finish = 1'b0;
        csr_rd(8'h01, rd);               check_eq("rd_done", rd, 32'h0);
        csr_rd(8'h10, rd);               check_eq("rdata0", rd, 32'hA0A1A2A3);
        csr_rd(8'h13, rd);               check_eq("rdata3", rd, 32'hA5A5A5A5);
`ifdef DDR3_BUF_REGS_IRQ_EN
        csr_rd(8'h05, rd);               check_eq("irqstat_done", rd, 32'h0001_0000);
        check_eq("irq_done_masked", irq, 1'b0);
        csr_wr(8'h05, 32'h0001_0000);
`endif

        csr_wr(8'h01, 32'h3);
        check_eq("both_wr_only", {test_wr_req, test_rd_req}, 2'b10);
        csr_rd(8'h01, rd);               check_eq("wr_busy", rd, 32'h1);
        wr_finish = 1'b1;
        @(negedge clk);
        wr_finish = 1'b0;
        csr_rd(8'h01, rd);               check_eq("wr_done", rd, 32'h0);

        csr_wr(8'h01, 32'h1);
        repeat (7) @(negedge clk);
        wr_finish = 1'b1;
        @(negedge clk);
        wr_finish = 1'b0;
        csr_rd(8'h01, rd);               check_eq("finish_beats_tmo", rd, 32'h0);

        csr_wr(8'h01, 32'h1);
        check_eq("tmo_wr_req", test_wr_req, 1'b1);
        csr_wr(8'h01, 32'h2);
        check_eq("busy_no_req", {test_wr_req, test_rd_req}, 2'b00);
        repeat (6) @(negedge clk);
        csr_rd(8'h01, rd);               check_eq("tmo_last_busy", rd, 32'h1);
        csr_rd(8'h01, rd);               check_eq("tmo_ctrl", rd, 32'h4);
        csr_rd(8'h02, rd);               check_eq("tmo_status", rd, 32'h0001_0000);
`ifdef DDR3_BUF_REGS_IRQ_EN
        csr_wr(8'h04, 32'h0001_0000);
        check_eq("irq_tmo", irq, 1'b1);
`endif
        csr_wr(8'h02, 32'h0001_0000);
        csr_rd(8'h02, rd);               check_eq("tmo_w1c", rd, 32'h0);

        csr_wr(8'h01, 32'h2);
        reset = 1'b1;
        bus.csr_write = 1'b1; bus.csr_addr = 8'h01; bus.csr_wr_data = 32'h1;
        @(negedge clk);
        bus.csr_write = 1'b0;
        check_eq("rst_no_req", {test_wr_req, test_rd_req}, 2'b00);
        check_eq("rst_mid_addr", test_addr, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        csr_rd(8'h01, rd);               check_eq("rst_abort", rd, 32'h0);
        check_eq("rst_irq", irq, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
